// File: rtl/reservation_station_if.sv
`default_nettype none
// ============================================================================
// Module  : reservation_station_if
// Brief   : Issue, result-bus and ALU-dispatch signals of the reservation station.
// Revision: 1.0
// ============================================================================
interface reservation_station_if #(
  parameter int ROB_W = 4
);
  logic             is_rs;
  logic [31:0]      pc_now_in;
  logic [ROB_W-1:0] entry_in;
  logic [5:0]       op_in;
  logic [31:0]      Vj;
  logic [31:0]      Vk;
  logic [ROB_W-1:0] Qj;
  logic [ROB_W-1:0] Qk;
  logic [31:0]      imm_in;
  logic             rs_full;

  logic             alu_cdb_en;
  logic [ROB_W-1:0] alu_cdb_tag;
  logic [31:0]      alu_cdb_val;
  logic             lsb_cdb_en;
  logic [ROB_W-1:0] lsb_cdb_tag;
  logic [31:0]      lsb_cdb_val;

  logic             alu_en;
  logic [5:0]       alu_op;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [31:0]      alu_imm;
  logic [31:0]      alu_pc;
  logic [ROB_W-1:0] alu_entry;

  modport master (
    output is_rs, pc_now_in, entry_in, op_in, Vj, Vk, Qj, Qk, imm_in,
    output alu_cdb_en, alu_cdb_tag, alu_cdb_val,
    output lsb_cdb_en, lsb_cdb_tag, lsb_cdb_val,
    input  rs_full,
    input  alu_en, alu_op, alu_a, alu_b, alu_imm, alu_pc, alu_entry
  );

  modport slave (
    input  is_rs, pc_now_in, entry_in, op_in, Vj, Vk, Qj, Qk, imm_in,
    input  alu_cdb_en, alu_cdb_tag, alu_cdb_val,
    input  lsb_cdb_en, lsb_cdb_tag, lsb_cdb_val,
    output rs_full,
    output alu_en, alu_op, alu_a, alu_b, alu_imm, alu_pc, alu_entry
  );
endinterface
`default_nettype wire

// File: rtl/reservation_station.sv
`default_nettype none
// ============================================================================
// Module  : reservation_station
// Brief   : Holds issued ALU instructions until operands arrive, dispatches one per cycle.
// Revision: 1.0
// ============================================================================
module reservation_station #(
  parameter int RS_SIZE = 16,
  parameter int ROB_W   = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             rdy,
  input  wire logic             clear,
  reservation_station_if.slave  bus
);

  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0] r_busy;
  logic [5:0]         r_op    [RS_SIZE];
  logic [31:0]        r_pc    [RS_SIZE];
  logic [31:0]        r_vj    [RS_SIZE];
  logic [31:0]        r_vk    [RS_SIZE];
  logic [ROB_W-1:0]   r_qj    [RS_SIZE];
  logic [ROB_W-1:0]   r_qk    [RS_SIZE];
  logic [31:0]        r_imm   [RS_SIZE];
  logic [ROB_W-1:0]   r_entry [RS_SIZE];

  logic               r_alu_en;
  logic [5:0]         r_alu_op;
  logic [31:0]        r_alu_a;
  logic [31:0]        r_alu_b;
  logic [31:0]        r_alu_imm;
  logic [31:0]        r_alu_pc;
  logic [ROB_W-1:0]   r_alu_entry;

  logic [RS_SIZE-1:0] w_ready;
  logic [RS_SIZE-1:0] w_j_alu, w_j_lsb, w_k_alu, w_k_lsb;
  logic [IDX_W-1:0]   w_free_idx;
  logic [IDX_W-1:0]   w_sel_idx;
  logic               w_sel_valid;
  logic               w_full;
  logic               w_alloc;
  logic [31:0]        w_in_vj, w_in_vk;
  logic [ROB_W-1:0]   w_in_qj, w_in_qk;

  assign w_full      = &r_busy;
  assign w_sel_valid = |w_ready;
  assign w_alloc     = bus.is_rs && !w_full;

  // A nonzero-tag compare is enough to keep tag 0 on a bus from waking anything.
  always_comb begin
    w_ready = '0;
    w_j_alu = '0;
    w_j_lsb = '0;
    w_k_alu = '0;
    w_k_lsb = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      w_ready[i] = r_busy[i] && (r_qj[i] == '0) && (r_qk[i] == '0);
      w_j_alu[i] = bus.alu_cdb_en && (r_qj[i] != '0) && (r_qj[i] == bus.alu_cdb_tag);
      w_j_lsb[i] = bus.lsb_cdb_en && (r_qj[i] != '0) && (r_qj[i] == bus.lsb_cdb_tag);
      w_k_alu[i] = bus.alu_cdb_en && (r_qk[i] != '0) && (r_qk[i] == bus.alu_cdb_tag);
      w_k_lsb[i] = bus.lsb_cdb_en && (r_qk[i] != '0) && (r_qk[i] == bus.lsb_cdb_tag);
    end
  end

  // Descending scans leave the lowest matching index in the result.
  always_comb begin
    w_free_idx = '0;
    w_sel_idx  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!r_busy[i]) w_free_idx = IDX_W'(i);
      if (w_ready[i]) w_sel_idx  = IDX_W'(i);
    end
  end

  always_comb begin
    w_in_vj = bus.Vj;
    w_in_qj = bus.Qj;
    if (bus.Qj != '0 && bus.alu_cdb_en && bus.Qj == bus.alu_cdb_tag) begin
      w_in_vj = bus.alu_cdb_val;
      w_in_qj = '0;
    end else if (bus.Qj != '0 && bus.lsb_cdb_en && bus.Qj == bus.lsb_cdb_tag) begin
      w_in_vj = bus.lsb_cdb_val;
      w_in_qj = '0;
    end
    w_in_vk = bus.Vk;
    w_in_qk = bus.Qk;
    if (bus.Qk != '0 && bus.alu_cdb_en && bus.Qk == bus.alu_cdb_tag) begin
      w_in_vk = bus.alu_cdb_val;
      w_in_qk = '0;
    end else if (bus.Qk != '0 && bus.lsb_cdb_en && bus.Qk == bus.lsb_cdb_tag) begin
      w_in_vk = bus.lsb_cdb_val;
      w_in_qk = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy      <= '0;
      r_alu_en    <= 1'b0;
      r_alu_op    <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_imm   <= '0;
      r_alu_pc    <= '0;
      r_alu_entry <= '0;
    end else if (clear) begin
      r_busy   <= '0;
      r_alu_en <= 1'b0;
    end else if (rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (r_busy[i]) begin
          if (w_j_alu[i]) begin
            r_vj[i] <= bus.alu_cdb_val;
            r_qj[i] <= '0;
          end else if (w_j_lsb[i]) begin
            r_vj[i] <= bus.lsb_cdb_val;
            r_qj[i] <= '0;
          end
          if (w_k_alu[i]) begin
            r_vk[i] <= bus.alu_cdb_val;
            r_qk[i] <= '0;
          end else if (w_k_lsb[i]) begin
            r_vk[i] <= bus.lsb_cdb_val;
            r_qk[i] <= '0;
          end
        end
      end

      r_alu_en <= w_sel_valid;
      if (w_sel_valid) begin
        r_busy[w_sel_idx] <= 1'b0;
        r_alu_op          <= r_op[w_sel_idx];
        r_alu_a           <= r_vj[w_sel_idx];
        r_alu_b           <= r_vk[w_sel_idx];
        r_alu_imm         <= r_imm[w_sel_idx];
        r_alu_pc          <= r_pc[w_sel_idx];
        r_alu_entry       <= r_entry[w_sel_idx];
      end

      // The free slot is never the selected one: selection needs busy=1.
      if (w_alloc) begin
        r_busy[w_free_idx]  <= 1'b1;
        r_op[w_free_idx]    <= bus.op_in;
        r_pc[w_free_idx]    <= bus.pc_now_in;
        r_imm[w_free_idx]   <= bus.imm_in;
        r_entry[w_free_idx] <= bus.entry_in;
        r_vj[w_free_idx]    <= w_in_vj;
        r_qj[w_free_idx]    <= w_in_qj;
        r_vk[w_free_idx]    <= w_in_vk;
        r_qk[w_free_idx]    <= w_in_qk;
      end
    end
  end

  assign bus.rs_full   = w_full;
  assign bus.alu_en    = r_alu_en;
  assign bus.alu_op    = r_alu_op;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_imm   = r_alu_imm;
  assign bus.alu_pc    = r_alu_pc;
  assign bus.alu_entry = r_alu_entry;

endmodule
`default_nettype wire

// File: tb/tb_reservation_station.sv
`default_nettype none
// ============================================================================
// Module  : tb_reservation_station
// Brief   : Directed bench with a queue-based behavioural model of the station.
// Revision: 1.0
// ============================================================================
module tb_reservation_station;

  localparam int RS = 16;

  logic clk = 1'b0;
  logic rst, rdy, clear;
  always #5 clk = ~clk;

  reservation_station_if #(.ROB_W(4)) bus ();

  reservation_station #(.RS_SIZE(RS), .ROB_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .clear (clear),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the station is a set of waiting instructions, each remembering its slot.
  typedef struct {
    int          slot;
    logic [5:0]  op;
    logic [31:0] pc, vj, vk, imm;
    logic [3:0]  qj, qk, tag;
  } ins_t;

  ins_t        mq[$];
  logic        m_en;
  logic [5:0]  m_op;
  logic [31:0] m_a, m_b, m_imm, m_pc;
  logic [3:0]  m_entry;

  function automatic void fwd(inout logic [3:0] q, inout logic [31:0] v);
    if (q != 0 && bus.alu_cdb_en && q == bus.alu_cdb_tag) begin
      v = bus.alu_cdb_val; q = 0;
    end else if (q != 0 && bus.lsb_cdb_en && q == bus.lsb_cdb_tag) begin
      v = bus.lsb_cdb_val; q = 0;
    end
  endfunction

  function automatic bit slot_used(input int s);
    foreach (mq[i]) if (mq[i].slot == s) return 1'b1;
    return 1'b0;
  endfunction

  int   pick, best, free_slot;
  bit   was_full;
  ins_t nw;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_en = 0; m_op = 0; m_a = 0; m_b = 0; m_imm = 0; m_pc = 0; m_entry = 0;
    end else if (clear) begin
      mq.delete();
      m_en = 0;
    end else if (rdy) begin
      was_full = (mq.size() == RS);
      pick = -1; best = RS;
      foreach (mq[i])
        if (mq[i].qj == 0 && mq[i].qk == 0 && mq[i].slot < best) begin
          best = mq[i].slot; pick = i;
        end
      free_slot = -1;
      for (int s = RS - 1; s >= 0; s--) if (!slot_used(s)) free_slot = s;
      m_en = (pick >= 0);
      if (pick >= 0) begin
        m_op = mq[pick].op; m_a = mq[pick].vj; m_b = mq[pick].vk;
        m_imm = mq[pick].imm; m_pc = mq[pick].pc; m_entry = mq[pick].tag;
      end
      foreach (mq[i]) begin
        fwd(mq[i].qj, mq[i].vj);
        fwd(mq[i].qk, mq[i].vk);
      end
      if (pick >= 0) mq.delete(pick);
      if (bus.is_rs && !was_full) begin
        nw.slot = free_slot; nw.op = bus.op_in; nw.pc = bus.pc_now_in;
        nw.imm = bus.imm_in; nw.tag = bus.entry_in;
        nw.vj = bus.Vj; nw.qj = bus.Qj; nw.vk = bus.Vk; nw.qk = bus.Qk;
        fwd(nw.qj, nw.vj);
        fwd(nw.qk, nw.vk);
        mq.push_back(nw);
      end
    end
  end

  bit chk_on = 1'b0;
  always @(negedge clk) begin
    if (chk_on) begin
      check("rs_full",   {31'b0, bus.rs_full}, {31'b0, mq.size() == RS});
      check("alu_en",    {31'b0, bus.alu_en},  {31'b0, m_en});
      check("alu_op",    {26'b0, bus.alu_op},  {26'b0, m_op});
      check("alu_a",     bus.alu_a,   m_a);
      check("alu_b",     bus.alu_b,   m_b);
      check("alu_imm",   bus.alu_imm, m_imm);
      check("alu_pc",    bus.alu_pc,  m_pc);
      check("alu_entry", {28'b0, bus.alu_entry}, {28'b0, m_entry});
    end
  end

  // Dispatch recorder: counts a strobe only when the producing edge was live.
  bit          rec_on = 1'b0;
  bit          live_edge;
  logic [31:0] rec_q[$];
  always @(posedge clk) live_edge = rdy && !rst && !clear;
  always @(negedge clk) if (rec_on && live_edge && bus.alu_en) rec_q.push_back(bus.alu_imm);

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.is_rs = 0; bus.pc_now_in = 0; bus.entry_in = 0; bus.op_in = 0;
    bus.Vj = 0; bus.Vk = 0; bus.Qj = 0; bus.Qk = 0; bus.imm_in = 0;
    bus.alu_cdb_en = 0; bus.alu_cdb_tag = 0; bus.alu_cdb_val = 0;
    bus.lsb_cdb_en = 0; bus.lsb_cdb_tag = 0; bus.lsb_cdb_val = 0;
  endtask

  task automatic put(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                     input logic [3:0] qj, input logic [3:0] qk, input logic [3:0] tag,
                     input logic [31:0] imm);
    bus.is_rs = 1; bus.op_in = op; bus.Vj = vj; bus.Vk = vk; bus.Qj = qj; bus.Qk = qk;
    bus.entry_in = tag; bus.imm_in = imm; bus.pc_now_in = 32'h1000 + imm;
  endtask

  task automatic run_seq(input bit freeze, output logic [31:0] got[$]);
    logic [31:0] held;
    rec_q.delete();
    rec_on = 1;
    for (int i = 0; i < 4; i++) begin
      put(6'd1, 32'(i), 32'd1, 4'd0, 4'd0, 4'd9, 32'(10 + i));
      tick();
    end
    bus.is_rs = 0;
    if (freeze) begin
      held = bus.alu_imm;
      rdy = 0;
      for (int i = 0; i < 4; i++) begin
        tick();
        check("freeze_en",  {31'b0, bus.alu_en}, 32'd1);
        check("freeze_imm", bus.alu_imm, held);
      end
      rdy = 1;
    end
    repeat (6) tick();
    rec_on = 0;
    got = rec_q;
  endtask

  logic [31:0] seq_a[$], seq_b[$];

  initial begin
    idle();
    rst = 1; rdy = 1; clear = 0;
    tick(); tick();
    chk_on = 1;
    check("reset_en",   {31'b0, bus.alu_en},  32'd0);
    check("reset_full", {31'b0, bus.rs_full}, 32'd0);
    check("reset_a",    bus.alu_a, 32'd0);
    rst = 0;

    // 1: ready instruction dispatches two edges after issue
    put(6'd3, 32'd5, 32'd7, 4'd0, 4'd0, 4'd2, 32'd0);
    tick(); idle();
    tick();
    check("t1_en",    {31'b0, bus.alu_en}, 32'd1);
    check("t1_a",     bus.alu_a, 32'd5);
    check("t1_b",     bus.alu_b, 32'd7);
    check("t1_op",    {26'b0, bus.alu_op}, 32'd3);
    check("t1_entry", {28'b0, bus.alu_entry}, 32'd2);
    tick();
    check("t1_en_low", {31'b0, bus.alu_en}, 32'd0);

    // 2: wakeup from ALU bus
    put(6'd4, 32'd0, 32'd1, 4'd4, 4'd0, 4'd5, 32'd0);
    tick(); idle();
    tick(); tick();
    bus.alu_cdb_en = 1; bus.alu_cdb_tag = 4; bus.alu_cdb_val = 32'hDEAD;
    tick(); idle();
    check("t2_wait", {31'b0, bus.alu_en}, 32'd0);
    tick();
    check("t2_en",    {31'b0, bus.alu_en}, 32'd1);
    check("t2_a",     bus.alu_a, 32'hDEAD);
    check("t2_entry", {28'b0, bus.alu_entry}, 32'd5);

    // 3: forwarding from LSB bus in the issue cycle
    put(6'd5, 32'd3, 32'd0, 4'd0, 4'd6, 4'd7, 32'd0);
    bus.lsb_cdb_en = 1; bus.lsb_cdb_tag = 6; bus.lsb_cdb_val = 32'd9;
    tick(); idle();
    tick();
    check("t3_en", {31'b0, bus.alu_en}, 32'd1);
    check("t3_b",  bus.alu_b, 32'd9);
    tick();

    // 4: fill, overflow issue dropped, in-order drain
    for (int i = 0; i < RS; i++) begin
      put(6'd2, 32'd0, 32'd2, 4'd1, 4'd0, 4'd8, 32'(i));
      tick();
    end
    check("t4_full", {31'b0, bus.rs_full}, 32'd1);
    put(6'd2, 32'd0, 32'd2, 4'd1, 4'd0, 4'd8, 32'd99);
    tick(); idle();
    check("t4_still_full", {31'b0, bus.rs_full}, 32'd1);
    bus.alu_cdb_en = 1; bus.alu_cdb_tag = 1; bus.alu_cdb_val = 32'h100;
    tick(); idle();
    for (int k = 0; k < RS; k++) begin
      tick();
      check("t4_order_en",  {31'b0, bus.alu_en}, 32'd1);
      check("t4_order_imm", bus.alu_imm, 32'(k));
    end
    tick();
    check("t4_drained", {31'b0, bus.alu_en}, 32'd0);

    // 5: clear beats a matching broadcast
    for (int i = 0; i < 3; i++) begin
      put(6'd6, 32'd0, 32'd0, 4'd3, 4'd0, 4'd4, 32'(40 + i));
      tick();
    end
    idle();
    clear = 1;
    bus.alu_cdb_en = 1; bus.alu_cdb_tag = 3; bus.alu_cdb_val = 32'd1;
    tick();
    clear = 0; idle();
    check("t5_full", {31'b0, bus.rs_full}, 32'd0);
    check("t5_en",   {31'b0, bus.alu_en},  32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_no_dispatch", {31'b0, bus.alu_en}, 32'd0);
    end

    // 6: stall with rdy=0 must not change the dispatch sequence
    run_seq(1'b0, seq_a);
    run_seq(1'b1, seq_b);
    check("t6_len_a", 32'(seq_a.size()), 32'd4);
    check("t6_len_b", 32'(seq_b.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t6_seq_a", (i < seq_a.size()) ? seq_a[i] : 32'hFFFF_FFFF, 32'(10 + i));
      check("t6_seq_b", (i < seq_b.size()) ? seq_b[i] : 32'hFFFF_FFFF, 32'(10 + i));
    end

    // Reset after activity restores the zeroed outputs.
    rst = 1;
    tick();
    rst = 0;
    check("rerst_a", bus.alu_a, 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
